fx2_slave_fifo_writer: RTL
==========================

Name: fx2_slave_fifo_writer

Overview:
- Downstream consumer of the 16->8 DAQ FIFO's read port.
- Pops bytes from that FIFO and writes them into the EZ-USB FX2 slave FIFO (EP6, synchronous mode) with SLWR strobes, honouring FLAGB (full).
- Commits short packets with PKTEND after an idle timeout or an explicit flush.
- Full 512-byte packets rely on FX2 auto-commit.
- Sits between the DAQ FIFO read side and the FX2 pins, in the read-clock (IFCLK) domain.

Parameters:
- PKT_BYTES, 512, FX2 endpoint packet size in bytes; counter wraps here.
- CNT_WIDTH, 10, width of the packet byte counter; must satisfy 2^CNT_WIDTH >= PKT_BYTES.
- TIMEOUT_CYCLES, 4096, idle cycles with FIFO empty and a partial packet pending before PKTEND.
- TO_WIDTH, 13, width of the idle counter.

Ports:
- clk  in  1  IFCLK; also drives the DAQ FIFO rdclk.
- clear_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits starting new byte transfers.
- flush  in  1  one-cycle pulse requesting commit of the partial packet.
- fifo_q  in  8  byte from the DAQ FIFO; valid the cycle after fifo_rdreq.
- fifo_rdempty  in  1  DAQ FIFO empty.
- fifo_rdreq  out  1  one-cycle pop request.
- usb_full_n  in  1  FX2 FLAGB; 0 = endpoint full.
- usb_fd  out  8  FX2 data bus.
- usb_slwr_n  out  1  FX2 write strobe, active low.
- usb_pktend_n  out  1  FX2 packet end, active low.
- usb_sloe_n  out  1  constant 1.
- usb_fifoadr  out  2  constant 2'b10 (EP6).
- pkt_count  out  CNT_WIDTH  bytes in the current uncommitted packet.
- stall_count  out  16  saturating count of cycles stalled on full.

Behaviour:
- All outputs are registered.
- Reset values: fifo_rdreq=0, usb_fd=0, usb_slwr_n=1, usb_pktend_n=1, usb_sloe_n=1, usb_fifoadr=2'b10, pkt_count=0, stall_count=0. State is IDLE, flush_pending=0, idle_cnt=0.
- States: IDLE, REQ, CAPTURE, WRITE, PKTEND. Encoding is one-hot or binary; the choice is free.
- IDLE:
  - If enable && !fifo_rdempty && usb_full_n, go to REQ.
  - Else if fifo_rdempty && pkt_count!=0 && (flush_pending || idle_cnt==TIMEOUT_CYCLES-1) && usb_full_n, go to PKTEND.
  - Otherwise stay in IDLE.
- REQ: fifo_rdreq=1 for exactly this one cycle; go to CAPTURE.
- CAPTURE: usb_fd <= fifo_q; go to WRITE.
- WRITE:
  - If usb_full_n=1: usb_slwr_n=0 for exactly the next cycle, then return to IDLE.
  - pkt_count increments; it wraps from PKT_BYTES-1 to 0 with no PKTEND (auto-commit).
  - If usb_full_n=0: hold usb_fd, keep usb_slwr_n=1, stay in WRITE, increment stall_count (saturates at 0xFFFF).
- Data-bus timing: usb_fd is stable from the cycle after CAPTURE through the SLWR-low cycle. Throughput is 1 byte per 4 clocks.
- PKTEND: usb_pktend_n=0 for one cycle; pkt_count<=0, idle_cnt<=0, flush_pending<=0; return to IDLE.
- idle_cnt:
  - Increments each cycle when in IDLE && fifo_rdempty && pkt_count!=0, saturating at TIMEOUT_CYCLES-1.
  - Clears on every SLWR strobe and on PKTEND.
- flush:
  - A flush pulse sets flush_pending.
  - If pkt_count==0 when flush would be serviced, flush_pending is cleared without PKTEND; zero-length packets are never sent.
  - Data pending in the FIFO takes priority over flush; flush is serviced once the FIFO is empty.
- enable=0: a byte already in REQ, CAPTURE or WRITE completes; no new REQ is issued. Timeout and flush still operate.
- Full de-asserting mid-packet: PKTEND is never issued while usb_full_n=0; the block waits in IDLE.
- Reset mid-operation: all registers and outputs go to reset values immediately. A byte already popped is discarded. SLWR and PKTEND never glitch low during reset.
- fifo_rdreq is never asserted when fifo_rdempty was 1 in the deciding IDLE cycle.

Decomposition:
- Shared package fx2_pkg holds:
  - state encodings,
  - FX2_EP6_ADDR = 2'b10,
  - default PKT_BYTES = 512,
  - STALL_WIDTH = 16.
- One sub-module, fx2_idle_timer: a saturating idle counter with clear and terminal-count output, parameterised by TIMEOUT_CYCLES/TO_WIDTH.

Test Plan:
- Single byte: write 0xA5 to the FIFO, enable=1, full_n=1 -> rdreq pulses once. usb_fd=0xA5 while slwr_n is low for one cycle. pkt_count=1. After 4096 empty cycles, pktend_n pulses once and pkt_count=0.
- Full packet: stream 512 bytes 0x00..0xFF repeating -> 512 SLWR strobes with data in order, pkt_count wraps to 0, no PKTEND pulse.
- Back-pressure: hold full_n=0 while in WRITE for 10 cycles -> usb_fd is held, no SLWR, stall_count=10. After release, exactly one SLWR with the correct byte.
- Flush: 3 bytes written, then a flush pulse -> PKTEND one cycle after the FIFO drains, before the timeout. A flush with pkt_count=0 produces no PKTEND.
- Enable drop: deassert enable during CAPTURE -> that byte still strobes; no further rdreq while the FIFO is non-empty.
- Reset mid-WRITE: assert clear_n=0 asynchronously -> slwr_n, pktend_n and sloe_n go to 1 and rdreq to 0 within the same cycle. pkt_count=0 and stall_count=0 after release.

Source files
------------

// File: rtl/fx2_pkg.sv
// Shared types and constants for the FX2 slave-FIFO writer.
// State encoding, EP6 FIFO address and counter widths.
package fx2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_PKTEND  = 3'd4
    } state_t;

    localparam logic [1:0] FX2_EP6_ADDR  = 2'b10;
    localparam int         DEF_PKT_BYTES = 512;
    localparam int         STALL_WIDTH   = 16;

endpackage

// File: rtl/fx2_slave_fifo_writer_if.sv
// DAQ FIFO read port plus FX2 slave-FIFO pins, grouped as one bus.
// master = the writer block, slave = the FIFO/FX2 side.
interface fx2_slave_fifo_writer_if;
    logic [7:0] fifo_q;
    logic       fifo_rdempty;
    logic       fifo_rdreq;
    logic       usb_full_n;
    logic [7:0] usb_fd;
    logic       usb_slwr_n;
    logic       usb_pktend_n;
    logic       usb_sloe_n;
    logic [1:0] usb_fifoadr;

    modport master (
        input  fifo_q, fifo_rdempty, usb_full_n,
        output fifo_rdreq, usb_fd, usb_slwr_n, usb_pktend_n, usb_sloe_n, usb_fifoadr
    );

    modport slave (
        output fifo_q, fifo_rdempty, usb_full_n,
        input  fifo_rdreq, usb_fd, usb_slwr_n, usb_pktend_n, usb_sloe_n, usb_fifoadr
    );
endinterface

// File: rtl/fx2_idle_timer.sv
// Saturating idle counter; tc is high while the count sits at TIMEOUT_CYCLES-1.
// Single-cycle registered count; clr has priority over inc.
module fx2_idle_timer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_WIDTH       = 13
) (
    input  logic clk,
    input  logic clear_n,
    input  logic inc,
    input  logic clr,
    output logic tc
);
    localparam logic [TO_WIDTH-1:0] TERM = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != TERM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TERM);
endmodule

// File: rtl/fx2_slave_fifo_writer.sv
// Pops DAQ FIFO bytes into FX2 EP6 with SLWR, one byte per 4 clocks; commits short packets with PKTEND.
// Stalls in WRITE (data held, SLWR high) while FLAGB reports full; never pops from an empty FIFO.
module fx2_slave_fifo_writer
    import fx2_pkg::*;
#(
    parameter int PKT_BYTES      = DEF_PKT_BYTES,
    parameter int CNT_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_WIDTH       = 13
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic                   enable,
    input  logic                   flush,
    fx2_slave_fifo_writer_if.master bus,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic [STALL_WIDTH-1:0] stall_count
);
    localparam logic [CNT_WIDTH-1:0]   PKT_LAST  = CNT_WIDTH'(PKT_BYTES - 1);
    localparam logic [STALL_WIDTH-1:0] STALL_MAX = {STALL_WIDTH{1'b1}};

    state_t                 state_q, state_d;
    logic                   flush_pending, flush_pending_d;
    logic                   idle_tc;
    logic                   rdreq_d, slwr_n_d, pktend_n_d;
    logic [7:0]             fd_d;
    logic [CNT_WIDTH-1:0]   pkt_d;
    logic [STALL_WIDTH-1:0] stall_d;

    logic pkt_nz, start_ok, commit_ok, strobe, in_idle, in_pktend;

    assign pkt_nz    = (pkt_count != '0);
    assign in_idle   = (state_q == ST_IDLE);
    assign in_pktend = (state_q == ST_PKTEND);
    assign start_ok  = enable && !bus.fifo_rdempty && bus.usb_full_n;
    assign commit_ok = bus.fifo_rdempty && pkt_nz && (flush_pending || idle_tc) && bus.usb_full_n;
    assign strobe    = (state_q == ST_WRITE) && bus.usb_full_n;

    fx2_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_WIDTH       (TO_WIDTH)
    ) u_idle_timer (
        .clk     (clk),
        .clear_n (clear_n),
        .inc     (in_idle && bus.fifo_rdempty && pkt_nz),
        .clr     (strobe || in_pktend),
        .tc      (idle_tc)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q          <= ST_IDLE;
            flush_pending    <= 1'b0;
            bus.fifo_rdreq   <= 1'b0;
            bus.usb_fd       <= 8'h00;
            bus.usb_slwr_n   <= 1'b1;
            bus.usb_pktend_n <= 1'b1;
            bus.usb_sloe_n   <= 1'b1;
            bus.usb_fifoadr  <= FX2_EP6_ADDR;
            pkt_count        <= '0;
            stall_count      <= '0;
        end else begin
            state_q          <= state_d;
            flush_pending    <= flush_pending_d;
            bus.fifo_rdreq   <= rdreq_d;
            bus.usb_fd       <= fd_d;
            bus.usb_slwr_n   <= slwr_n_d;
            bus.usb_pktend_n <= pktend_n_d;
            bus.usb_sloe_n   <= 1'b1;
            bus.usb_fifoadr  <= FX2_EP6_ADDR;
            pkt_count        <= pkt_d;
            stall_count      <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok)       state_d = ST_REQ;
                else if (commit_ok) state_d = ST_PKTEND;
            end
            ST_REQ:     state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_WRITE;
            ST_WRITE:   if (bus.usb_full_n) state_d = ST_IDLE;
            ST_PKTEND:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdreq_d    = (state_d == ST_REQ);
        pktend_n_d = (state_d != ST_PKTEND);
        slwr_n_d   = !strobe;
        fd_d       = (state_q == ST_CAPTURE) ? bus.fifo_q : bus.usb_fd;

        // Full packets wrap to zero and are committed by the FX2 itself.
        pkt_d = pkt_count;
        if (strobe)         pkt_d = (pkt_count == PKT_LAST) ? '0 : pkt_count + 1'b1;
        else if (in_pktend) pkt_d = '0;

        stall_d = stall_count;
        if ((state_q == ST_WRITE) && !bus.usb_full_n && (stall_count != STALL_MAX))
            stall_d = stall_count + 1'b1;

        // A new pulse wins over any same-cycle clear so it is never lost.
        flush_pending_d = flush_pending;
        if (flush)                                          flush_pending_d = 1'b1;
        else if (in_pktend)                                 flush_pending_d = 1'b0;
        else if (in_idle && bus.fifo_rdempty && !pkt_nz)    flush_pending_d = 1'b0;
    end
endmodule
